// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive-side controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver samples each bit this many times per prescale unit.
    localparam int UART_OVERSAMPLE    = 8;
    // One character on the wire: start + 8 data + stop.
    localparam int UART_BITS_PER_CHAR = 10;
    // Width of the idle-timeout counter and its limit.
    localparam int TIMEOUT_W          = 32;

    // Per-cycle FIFO activity as seen by the controller.
    typedef struct packed {
        logic push;   // character written into the FIFO
        logic pop;    // head entry consumed
        logic drop;   // character lost because the FIFO was full
    } fifo_evt_t;

    // Idle clocks before a timeout: prescale * oversample * bits * chars.
    // Evaluated in TIMEOUT_W bits; a zero result disables the timeout.
    function automatic logic [TIMEOUT_W-1:0] timeout_limit(
        input logic [15:0] prescale,
        input int          chars
    );
        logic [TIMEOUT_W-1:0] per_char;
        per_char = TIMEOUT_W'(UART_OVERSAMPLE * UART_BITS_PER_CHAR);
        return TIMEOUT_W'(prescale) * per_char * TIMEOUT_W'(chars);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Character stream from the UART receiver into the RX controller.
// Latency: n/a (wiring only).
// Backpressure: tready is driven by the consumer; this controller holds it high.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    // Receiver side drives the character.
    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    // Controller side consumes it.
    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received characters.
// Latency: write visible at dout/count the cycle after push; pop advances the head next cycle.
// Backpressure: push ignored while full unless a pop happens in the same cycle; flush overrides both.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  pop_ok;
    logic                  push_ok;

    // Occupancy and flags come only from registered pointers.
    assign count = CW'(wr_ptr - rd_ptr);
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CW'(FIFO_DEPTH));

    // A pop frees a slot in the same cycle, so push-while-full is allowed alongside it.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head of the queue, forced to zero when nothing is stored.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed since dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// RX controller: buffers receiver characters, latches error pulses, raises threshold/timeout/error irqs.
// Latency: character readable one cycle after acceptance; status and irq flags update one cycle after their cause.
// Backpressure: tready is held high out of reset; characters arriving while full are dropped and flagged.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CHARS = 4,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [15:0]           prescale,
    uart_rx_ctrl_if.slave         s_axis,
    input  logic                  rx_busy,
    input  logic                  rx_overrun,
    input  logic                  rx_frame,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush,
    input  logic [CW-1:0]         thresh,
    input  logic                  err_clr,
    input  logic                  err_irq_en,
    output logic [CW-1:0]         fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  err_overrun,
    output logic                  err_frame,
    output logic                  irq_thresh,
    output logic                  irq_timeout,
    output logic                  irq
);

    logic                 ready_q;
    logic                 wr_req;
    fifo_evt_t            evt;
    logic                 activity;
    logic [TIMEOUT_W-1:0] limit;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [TIMEOUT_W-1:0] to_cnt_nxt;
    logic                 to_set;

    // The receiver has no way to stall, so ready simply tracks being out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end
    assign s_axis.tready = ready_q;

    // Disabled receive discards characters without touching the FIFO or flags.
    assign wr_req = s_axis.tvalid && enable;

    // Classify this cycle's FIFO activity from registered occupancy.
    always_comb begin
        evt      = '0;
        evt.pop  = rd_en && !fifo_empty;
        evt.push = wr_req && (!fifo_full || evt.pop);
        evt.drop = wr_req && !evt.push;
    end

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt.push),
        .pop   (evt.pop),
        .flush (flush),
        .din   (s_axis.tdata),
        .dout  (rd_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky error capture; a new event in the clear cycle survives the clear.
    // A drop during flush is swallowed: the character was being discarded anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_overrun <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            if (rx_overrun || (evt.drop && !flush)) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end
            if (rx_frame) begin
                err_frame <= 1'b1;
            end else if (err_clr) begin
                err_frame <= 1'b0;
            end
        end
    end

    // Level threshold interrupt, sampled from the registered occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_thresh <= 1'b0;
        end else begin
            irq_thresh <= (thresh != '0) && (fifo_count >= thresh);
        end
    end

    // Idle limit tracks the receiver's prescale so timeout is in character times.
    assign limit    = timeout_limit(prescale, TIMEOUT_CHARS);
    assign activity = flush || evt.push || evt.pop;

    // Next idle count: restart on any FIFO activity or line activity, else
    // count up while data waits, saturating at the limit.
    always_comb begin
        to_cnt_nxt = to_cnt;
        to_set     = 1'b0;
        if (activity || rx_busy || (limit == '0)) begin
            to_cnt_nxt = '0;
        end else if (!fifo_empty) begin
            to_cnt_nxt = (to_cnt >= limit) ? limit : to_cnt + 1'b1;
        end
        // Flag fires in the same cycle the counter arrives at the limit.
        to_set = (limit != '0) && !fifo_empty && (to_cnt_nxt == limit);
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nxt;
        end
    end

    // Timeout interrupt holds until the FIFO is touched or flushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_timeout <= 1'b0;
        end else if (activity) begin
            irq_timeout <= 1'b0;
        end else if (to_set) begin
            irq_timeout <= 1'b1;
        end
    end

    // Combined interrupt from registered sources only.
    assign irq = irq_thresh || irq_timeout || (err_irq_en && (err_overrun || err_frame));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed steps then random traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TCH   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [15:0]   prescale;
    logic          rx_busy;
    logic          rx_overrun;
    logic          rx_frame;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          flush;
    logic [CW-1:0] thresh;
    logic          err_clr;
    logic          err_irq_en;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          err_overrun;
    logic          err_frame;
    logic          irq_thresh;
    logic          irq_timeout;
    logic          irq;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) axis_if ();

    uart_rx_ctrl #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CHARS (TCH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .prescale    (prescale),
        .s_axis      (axis_if),
        .rx_busy     (rx_busy),
        .rx_overrun  (rx_overrun),
        .rx_frame    (rx_frame),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .flush       (flush),
        .thresh      (thresh),
        .err_clr     (err_clr),
        .err_irq_en  (err_irq_en),
        .fifo_count  (fifo_count),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .err_overrun (err_overrun),
        .err_frame   (err_frame),
        .irq_thresh  (irq_thresh),
        .irq_timeout (irq_timeout),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of stored characters plus flags and an idle-cycle tally.
    logic [DW-1:0] mq[$];
    bit            m_ov, m_fr, m_ith, m_ito;
    longint        m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 0; m_fr = 0; m_ith = 0; m_ito = 0; m_idle = 0;
    endtask

    // Compare every observable output against the model.
    task automatic compare_all();
        logic [DW-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check("count",       32'(fifo_count),  32'(mq.size()));
        check("empty",       32'(fifo_empty),  32'(mq.size() == 0));
        check("full",        32'(fifo_full),   32'(mq.size() == DEPTH));
        check("rd_data",     32'(rd_data),     32'(head));
        check("tready",      32'(axis_if.tready), 32'd1);
        check("err_overrun", 32'(err_overrun), 32'(m_ov));
        check("err_frame",   32'(err_frame),   32'(m_fr));
        check("irq_thresh",  32'(irq_thresh),  32'(m_ith));
        check("irq_timeout", 32'(irq_timeout), 32'(m_ito));
        check("irq",         32'(irq),         32'(m_ith | m_ito | (err_irq_en & (m_ov | m_fr))));
    endtask

    // Advance one clock: update the model from the inputs presented, then check.
    task automatic tick();
        int     sz;
        bit     empty_b, full_b, pop_ok, push_req, push_ok, drop, act;
        longint lim;
        sz       = mq.size();
        empty_b  = (sz == 0);
        full_b   = (sz == DEPTH);
        pop_ok   = rd_en && !empty_b;
        push_req = axis_if.tvalid && enable;
        push_ok  = push_req && (!full_b || pop_ok);
        drop     = push_req && !push_ok;
        act      = flush || push_ok || pop_ok;
        lim      = longint'(prescale) * 8 * 10 * TCH;

        m_ith = (thresh != 0) && (sz >= int'(thresh));

        if (act || rx_busy || lim == 0) m_idle = 0;
        else if (!empty_b) m_idle = (m_idle >= lim) ? lim : m_idle + 1;

        if (act) m_ito = 0;
        else if (lim != 0 && !empty_b && m_idle == lim) m_ito = 1;

        if (flush) mq.delete();
        else begin
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(axis_if.tdata);
        end

        if (rx_overrun || (drop && !flush)) m_ov = 1;
        else if (err_clr) m_ov = 0;
        if (rx_frame) m_fr = 1;
        else if (err_clr) m_fr = 0;

        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        axis_if.tvalid = 0; rd_en = 0; flush = 0; err_clr = 0;
        rx_overrun = 0; rx_frame = 0; rx_busy = 0;
    endtask

    initial begin
        int seen;
        bit saw;
        rst = 0; enable = 0; prescale = 0; thresh = 0; err_irq_en = 0;
        axis_if.tdata = 0;
        idle_inputs();
        model_reset();

        // Reset state
        @(posedge clk); #1;
        check("rst_tready", 32'(axis_if.tready), 32'd0);
        check("rst_count",  32'(fifo_count),     32'd0);
        check("rst_empty",  32'(fifo_empty),     32'd1);
        check("rst_rdata",  32'(rd_data),        32'd0);
        check("rst_irq",    32'(irq),            32'd0);
        rst = 1;
        tick();

        // Three characters in, three out in order
        enable = 1;
        axis_if.tvalid = 1;
        axis_if.tdata = 8'h41; tick();
        axis_if.tdata = 8'h42; tick();
        axis_if.tdata = 8'h43; tick();
        axis_if.tvalid = 0;
        check("abc_count", 32'(fifo_count), 32'd3);
        check("abc_head",  32'(rd_data),    32'h41);
        for (int i = 0; i < 3; i++) begin
            check("abc_pop_data", 32'(rd_data), 32'h41 + i);
            rd_en = 1; tick();
        end
        rd_en = 0;
        check("abc_empty", 32'(fifo_empty), 32'd1);
        check("abc_rd0",   32'(rd_data),    32'd0);

        // Empty pop ignored, disabled receive drops silently
        rd_en = 1; tick(); rd_en = 0;
        enable = 0; axis_if.tvalid = 1; axis_if.tdata = 8'h55; tick();
        axis_if.tvalid = 0; enable = 1;
        check("dis_count", 32'(fifo_count),  32'd0);
        check("dis_noerr", 32'(err_overrun), 32'd0);

        // Overfill: 17 pushes, last one dropped
        axis_if.tvalid = 1;
        for (int i = 0; i < 17; i++) begin
            axis_if.tdata = 8'(8'h10 + i); tick();
        end
        axis_if.tvalid = 0;
        check("of_full",    32'(fifo_full),   32'd1);
        check("of_overrun", 32'(err_overrun), 32'd1);
        err_clr = 1; tick(); err_clr = 0;
        axis_if.tvalid = 1; rd_en = 1; axis_if.tdata = 8'hEE; tick();
        axis_if.tvalid = 0; rd_en = 0;
        check("pp_count", 32'(fifo_count),  32'd16);
        check("pp_noerr", 32'(err_overrun), 32'd0);
        check("pp_head",  32'(rd_data),     32'h11);
        flush = 1; tick(); flush = 0;

        // Threshold interrupt
        thresh = 4;
        axis_if.tvalid = 1;
        for (int i = 0; i < 4; i++) begin
            axis_if.tdata = 8'($urandom); tick();
        end
        axis_if.tvalid = 0;
        check("th_not_yet", 32'(irq_thresh), 32'd0);
        tick();
        check("th_set", 32'(irq_thresh), 32'd1);
        rd_en = 1; tick(); rd_en = 0;
        tick();
        check("th_clr", 32'(irq_thresh), 32'd0);
        thresh = 0;
        axis_if.tvalid = 1;
        for (int i = 0; i < 6; i++) begin
            axis_if.tdata = 8'($urandom); tick();
        end
        axis_if.tvalid = 0;
        tick(); tick();
        check("th_disabled", 32'(irq_thresh), 32'd0);
        flush = 1; tick(); flush = 0;

        // Character timeout at prescale=2: 2*8*10*4 idle clocks
        prescale = 2;
        axis_if.tvalid = 1; axis_if.tdata = 8'h5A; tick(); axis_if.tvalid = 0;
        seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (irq_timeout) begin seen = k; break; end
        end
        check("to_cycles", 32'(seen), 32'd640);
        rd_en = 1; tick(); rd_en = 0;
        check("to_pop_clr", 32'(irq_timeout), 32'd0);

        // prescale=0 disables the timeout
        prescale = 0;
        axis_if.tvalid = 1; axis_if.tdata = 8'h77; tick(); axis_if.tvalid = 0;
        saw = 0;
        for (int k = 0; k < 700; k++) begin
            tick();
            if (irq_timeout) saw = 1;
        end
        check("to_disabled", 32'(saw), 32'd0);
        flush = 1; tick(); flush = 0;

        // Sticky frame error vs clear
        rx_frame = 1; err_clr = 1; tick(); rx_frame = 0; err_clr = 0;
        check("fr_set_wins", 32'(err_frame), 32'd1);
        err_irq_en = 1; #1;
        check("fr_irq", 32'(irq), 32'd1);
        err_clr = 1; tick(); err_clr = 0;
        check("fr_clr",     32'(err_frame), 32'd0);
        check("fr_irq_clr", 32'(irq),       32'd0);

        // Flush overrides a simultaneous push
        prescale = 2;
        axis_if.tvalid = 1;
        for (int i = 0; i < 5; i++) begin
            axis_if.tdata = 8'($urandom); tick();
        end
        flush = 1; tick(); flush = 0; axis_if.tvalid = 0;
        check("fl_count", 32'(fifo_count),  32'd0);
        check("fl_to",    32'(irq_timeout), 32'd0);

        // Random traffic with frequent activity
        prescale = 1;
        for (int k = 0; k < 500; k++) begin
            axis_if.tvalid = ($urandom_range(0, 1) == 1);
            axis_if.tdata  = 8'($urandom);
            enable         = ($urandom_range(0, 9) != 0);
            rd_en          = ($urandom_range(0, 9) < 4);
            flush          = ($urandom_range(0, 31) == 0);
            rx_overrun     = ($urandom_range(0, 31) == 0);
            rx_frame       = ($urandom_range(0, 31) == 0);
            err_clr        = ($urandom_range(0, 15) == 0);
            rx_busy        = ($urandom_range(0, 4) == 0);
            err_irq_en     = ($urandom_range(0, 1) == 1);
            if (k % 50 == 0) thresh = CW'($urandom_range(0, DEPTH));
            tick();
        end
        idle_inputs(); enable = 1;

        // Random sparse traffic so the timeout has room to fire
        for (int k = 0; k < 2500; k++) begin
            axis_if.tvalid = ($urandom_range(0, 199) == 0);
            axis_if.tdata  = 8'($urandom);
            rd_en          = ($urandom_range(0, 399) == 0);
            tick();
        end
        idle_inputs();

        // Asynchronous reset in the middle of receiving
        axis_if.tvalid = 1; axis_if.tdata = 8'h99; tick(); tick();
        rx_frame = 1; tick(); rx_frame = 0;
        #3;
        rst = 0;
        #1;
        check("arst_count",  32'(fifo_count),     32'd0);
        check("arst_empty",  32'(fifo_empty),     32'd1);
        check("arst_rdata",  32'(rd_data),        32'd0);
        check("arst_tready", 32'(axis_if.tready), 32'd0);
        check("arst_errs",   32'({err_overrun, err_frame}), 32'd0);
        check("arst_irqs",   32'({irq_thresh, irq_timeout, irq}), 32'd0);
        model_reset();
        axis_if.tvalid = 0;
        @(posedge clk); #1;
        rst = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the AXI4-Stream UART receiver and the peripheral register bank. Accepts received characters, buffers them in an RX FIFO and latches the receiver's error pulses into sticky status. Generates threshold, character-timeout and error interrupts. Timeout is scaled from the same prescale value that configures the receiver.

Parameters:
DATA_WIDTH, 8, character width; must match receiver.
FIFO_DEPTH, 16, RX FIFO entries; power of 2, >=2.
TIMEOUT_CHARS, 4, idle character times before timeout interrupt.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
enable  in  1  receive enable; 0 = incoming characters discarded
prescale  in  16  receiver prescale (clocks per bit = prescale*8)
s_axis_tdata  in  DATA_WIDTH  character from receiver
s_axis_tvalid  in  1  character valid
s_axis_tready  out  1  always 1 out of reset
rx_busy  in  1  receiver busy
rx_overrun  in  1  receiver overrun pulse
rx_frame  in  1  receiver frame-error pulse
rd_en  in  1  pop request from register read
rd_data  out  DATA_WIDTH  FIFO head (first-word-fall-through)
flush  in  1  clear FIFO and timeout state
thresh  in  $clog2(FIFO_DEPTH)+1  interrupt threshold; 0 = disabled
err_clr  in  1  clear sticky errors
err_irq_en  in  1  include errors in irq
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
fifo_empty  out  1  count==0
fifo_full  out  1  count==FIFO_DEPTH
err_overrun  out  1  sticky: receiver overrun or FIFO drop
err_frame  out  1  sticky frame error
irq_thresh  out  1  level, registered
irq_timeout  out  1  sticky until cleared
irq  out  1  combined interrupt

Behaviour:
- Reset (rst low, async): FIFO empty, pointers 0, rd_data 0, sticky flags 0, all irqs 0, timeout counter 0. s_axis_tready 0 while in reset, 1 afterwards.
- Push: on s_axis_tvalid && enable && !full, the character is written; count updates next cycle.
- Valid while full and enable: character dropped; err_overrun set.
- Valid while !enable: character dropped silently; no flag.
- Pop: rd_en && !empty advances the read pointer. rd_data always shows the head; it is 0 when empty.
- rd_en on empty: ignored.
- Push and pop in the same cycle while full: both occur, count stays FIFO_DEPTH, no drop.
- Push and pop in the same cycle while empty: only the push occurs.
- flush: pointers, count, timeout counter and irq_timeout cleared next cycle. It overrides any push or pop in the same cycle; that character is lost with no flag. Sticky errors are unaffected.
- Sticky errors: rx_overrun or FIFO drop sets err_overrun; rx_frame sets err_frame. err_clr clears both. A set in the same cycle as err_clr wins.
- irq_thresh: registered; next cycle equals thresh!=0 && count>=thresh.
- Timeout counter:
  - 32-bit; limit = prescale*8*10*TIMEOUT_CHARS, computed in 32 bits.
  - Counter resets to 0 on push, pop, flush, or while rx_busy=1.
  - Otherwise it increments while FIFO non-empty, saturating at the limit.
  - When the counter equals the limit and the FIFO is non-empty, irq_timeout sets.
  - irq_timeout clears on push, pop or flush.
  - prescale==0 disables the timeout: counter held at 0, irq_timeout never sets.
- irq = irq_thresh | irq_timeout | (err_irq_en & (err_overrun | err_frame)); combinational from registers.
- fifo_count, fifo_empty and fifo_full are derived from registered state; no combinational path from rd_en or s_axis_tvalid.

Decomposition:
- Package uart_pkg: UART_OVERSAMPLE=8, UART_BITS_PER_CHAR=10 (start+8+stop), timeout-width constant.
- Sub-module uart_rx_fifo: synchronous FIFO, first-word-fall-through. Ports: push, pop, flush, din, dout, count, full, empty. Pointers one bit wider than the address for full/empty detection.
- Controller holds the flags, timeout counter and irq logic.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 with enable=1 -> count=3; rd_data=0x41; three rd_en pulses return 0x41, 0x42, 0x43; then empty=1, rd_data=0.
- Push 17 characters with FIFO_DEPTH=16 -> full=1, 17th dropped, err_overrun=1. Push and pop in the same cycle while full -> count stays 16, no new error.
- thresh=4, push 4 characters -> irq_thresh=1 the cycle after count reaches 4. One pop -> irq_thresh=0 next cycle. thresh=0 -> irq_thresh never asserts.
- prescale=2, TIMEOUT_CHARS=4, push one character, rx_busy=0 -> irq_timeout asserts exactly 640 cycles after the push. A pop clears it. prescale=0 -> irq_timeout never asserts.
- Pulse rx_frame together with err_clr -> err_frame=1. A later err_clr alone -> 0. err_irq_en=1 -> irq follows err_frame.
- Fill 5 characters, assert flush together with a push -> count=0 next cycle, irq_timeout=0. Deassert rst mid-receive -> all outputs return to their reset values asynchronously.
